// File: rtl/bus_timer_pkg.sv
// ============================================================================
// Module      : bus_timer_pkg
// Description : Shared constants and helpers for the memory-mapped machine
//               timer: register offsets (word index = addr[4:2]), the mtimecmp
//               reset value and a byte-enable merge function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_timer_pkg;

   // Register word indices decoded from addr[4:2]
   localparam logic [2:0] MTIME_LO    = 3'd0;
   localparam logic [2:0] MTIME_HI    = 3'd1;
   localparam logic [2:0] MTIMECMP_LO = 3'd2;
   localparam logic [2:0] MTIMECMP_HI = 3'd3;
   localparam logic [2:0] PRESCALE    = 3'd4;

   localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

   // Per-byte merge of write data into an existing 32-bit register value
   function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
// ============================================================================
// Module      : timer_prescaler
// Description : Tick generator for the machine timer. A 16-bit counter runs
//               0..prescale_i; tick_o is high in the cycle the counter equals
//               prescale_i, after which the counter restarts at 0. A prescale
//               of 0 therefore ticks every cycle. clear_i restarts the count.
// Ports       : clk_i      - system clock
//               rst_ni     - asynchronous active-low reset
//               prescale_i - terminal count
//               clear_i    - restart counter at 0 (prescale register written)
//               tick_o     - mtime increment strobe
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_prescaler (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [15:0] prescale_i,
   input  logic        clear_i,
   output logic        tick_o
);

   logic [15:0] r_count;

   assign tick_o = (r_count == prescale_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_count <= 16'd0;
      end else if (clear_i || tick_o) begin
         r_count <= 16'd0;
      end else begin
         r_count <= r_count + 16'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bus_timer.sv
// ============================================================================
// Module      : bus_timer
// Description : 64-bit memory-mapped machine timer (mtime/mtimecmp) acting as
//               a responder on the shared device bus. Every request gets one
//               rvalid the following cycle; reads return pre-update values,
//               write responses carry zero data. timer_intr_o is a registered
//               unsigned compare mtime >= mtimecmp.
//               Optional feature macro: IBEX_DEMO_TIMER_PRESCALE_EN adds a
//               16-bit PRESCALE register at offset 4 and a tick prescaler.
// Ports       : clk_i, rst_ni (async active-low)
//               device_req_i/addr_i/we_i/be_i/wdata_i - request side
//               device_rvalid_o/rdata_o               - response side
//               timer_intr_o                          - level timer interrupt
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_timer
   import bus_timer_pkg::*;
#(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 device_req_i,
   input  logic [AddrWidth-1:0] device_addr_i,
   input  logic                 device_we_i,
   input  logic [3:0]           device_be_i,
   input  logic [DataWidth-1:0] device_wdata_i,
   output logic                 device_rvalid_o,
   output logic [DataWidth-1:0] device_rdata_o,
   output logic                 timer_intr_o
);

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic [63:0] mtime_d;
   logic [31:0] rdata_d;
   logic [2:0]  reg_idx;
   logic        wr;
   logic        wr_any_be;
   logic        tick;

   logic unused_addr;
   assign unused_addr = ^{device_addr_i[AddrWidth-1:5], device_addr_i[1:0]};

   assign reg_idx   = device_addr_i[4:2];
   assign wr        = device_req_i && device_we_i;
   assign wr_any_be = wr && (device_be_i != 4'b0000);

`ifdef IBEX_DEMO_TIMER_PRESCALE_EN
   logic [15:0] prescale;
   logic [31:0] prescale_merged;
   logic [15:0] unused_prescale_hi;
   logic        prescale_wr;

   assign prescale_wr        = wr && (reg_idx == PRESCALE);
   assign prescale_merged    = be_merge({16'h0000, prescale}, device_wdata_i, device_be_i);
   assign unused_prescale_hi = prescale_merged[31:16];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prescale <= 16'd0;
      end else if (prescale_wr) begin
         prescale <= prescale_merged[15:0];
      end
   end

   timer_prescaler u_prescaler (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .prescale_i (prescale),
      .clear_i    (prescale_wr),
      .tick_o     (tick)
   );
`else
   assign tick = 1'b1;
`endif

   // A write to one mtime half replaces that half and freezes the other at
   // its pre-tick value, so no carry crosses halves in a write cycle.
   always_comb begin
      mtime_d = tick ? (mtime + 64'd1) : mtime;
      if (wr_any_be && (reg_idx == MTIME_LO)) begin
         mtime_d = {mtime[63:32], be_merge(mtime[31:0], device_wdata_i, device_be_i)};
      end else if (wr_any_be && (reg_idx == MTIME_HI)) begin
         mtime_d = {be_merge(mtime[63:32], device_wdata_i, device_be_i), mtime[31:0]};
      end
   end

   always_comb begin
      rdata_d = 32'h0000_0000;
      if (device_req_i && !device_we_i) begin
         case (reg_idx)
            MTIME_LO:    rdata_d = mtime[31:0];
            MTIME_HI:    rdata_d = mtime[63:32];
            MTIMECMP_LO: rdata_d = mtimecmp[31:0];
            MTIMECMP_HI: rdata_d = mtimecmp[63:32];
`ifdef IBEX_DEMO_TIMER_PRESCALE_EN
            PRESCALE:    rdata_d = {16'h0000, prescale};
`endif
            default:     rdata_d = 32'h0000_0000;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mtime           <= 64'd0;
         mtimecmp        <= MTIMECMP_RESET;
         device_rvalid_o <= 1'b0;
         device_rdata_o  <= '0;
         timer_intr_o    <= 1'b0;
      end else begin
         mtime           <= mtime_d;
         device_rvalid_o <= device_req_i;
         device_rdata_o  <= rdata_d;
         // Compare uses current register values, so the interrupt lags by one cycle
         timer_intr_o    <= (mtime >= mtimecmp);
         if (wr_any_be && (reg_idx == MTIMECMP_LO)) begin
            mtimecmp[31:0] <= be_merge(mtimecmp[31:0], device_wdata_i, device_be_i);
         end
         if (wr_any_be && (reg_idx == MTIMECMP_HI)) begin
            mtimecmp[63:32] <= be_merge(mtimecmp[63:32], device_wdata_i, device_be_i);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bus_timer.sv
// ============================================================================
// Module      : tb_bus_timer
// Description : Directed self-checking bench for bus_timer. Inputs change on
//               the falling edge, outputs are sampled on the falling edge.
//               Negedge k after reset release sees mtime == k (no pipeline
//               offset on reads); each bus access takes exactly one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_timer;

   logic        clk;
   logic        rst_ni;
   logic        req;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;
   logic        intr;

   int checks = 0;
   int errors = 0;

   logic [31:0] rd;
   logic        vld;

   bus_timer #(.DataWidth(32), .AddrWidth(32)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .device_req_i    (req),
      .device_addr_i   (addr),
      .device_we_i     (we),
      .device_be_i     (be),
      .device_wdata_i  (wdata),
      .device_rvalid_o (rvalid),
      .device_rdata_o  (rdata),
      .timer_intr_o    (intr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns one cycle later at the next falling edge
   task automatic bus(input logic w, input logic [2:0] off, input logic [3:0] b,
                      input logic [31:0] d, output logic [31:0] r, output logic v);
      req   = 1'b1;
      we    = w;
      addr  = {27'd0, off, 2'b00};
      be    = b;
      wdata = d;
      @(negedge clk);
      req   = 1'b0;
      we    = 1'b0;
      r     = rdata;
      v     = rvalid;
   endtask

   initial begin
      rst_ni = 1'b0;
      req    = 1'b0;
      addr   = 32'd0;
      we     = 1'b0;
      be     = 4'd0;
      wdata  = 32'd0;

      repeat (3) @(negedge clk);
      check("rst_rvalid", {63'd0, rvalid}, 64'd0);
      check("rst_rdata", {32'd0, rdata}, 64'd0);
      check("rst_intr", {63'd0, intr}, 64'd0);
      rst_ni = 1'b1;                                   // negedge 0

      repeat (10) @(negedge clk);                      // negedge 10
      bus(1'b0, 3'd0, 4'hF, 32'd0, rd, vld);           // -> 11
      check("idle_rvalid", {63'd0, vld}, 64'd1);
      check("idle_mtime_lo", {32'd0, rd}, 64'd10);
      check("idle_intr", {63'd0, intr}, 64'd0);

      bus(1'b1, 3'd3, 4'hF, 32'd0, rd, vld);           // -> 12
      check("wr_rdata_zero", {32'd0, rd}, 64'd0);
      bus(1'b1, 3'd2, 4'hF, 32'h20, rd, vld);          // -> 13
      repeat (19) @(negedge clk);                      // 32: mtime == cmp
      check("intr_at_match", {63'd0, intr}, 64'd0);
      @(negedge clk);                                  // 33
      check("intr_rise", {63'd0, intr}, 64'd1);
      bus(1'b0, 3'd0, 4'hF, 32'd0, rd, vld);           // -> 34
      check("mtime_at_33", {32'd0, rd}, 64'd33);
      bus(1'b1, 3'd2, 4'hF, 32'hFFFF_FFFF, rd, vld);   // -> 35
      check("intr_hold", {63'd0, intr}, 64'd1);
      @(negedge clk);                                  // 36
      check("intr_fall", {63'd0, intr}, 64'd0);

      // Carry from low half into high half
      bus(1'b1, 3'd0, 4'hF, 32'hFFFF_FFFF, rd, vld);   // -> 37
      bus(1'b0, 3'd1, 4'hF, 32'd0, rd, vld);           // -> 38
      check("carry_hi_pre", {32'd0, rd}, 64'd0);
      bus(1'b0, 3'd0, 4'hF, 32'd0, rd, vld);           // -> 39
      check("carry_lo", {32'd0, rd}, 64'd0);
      bus(1'b0, 3'd1, 4'hF, 32'd0, rd, vld);           // -> 40
      check("carry_hi", {32'd0, rd}, 64'd1);

      // Wrap from all-ones; low half kept at its pre-tick value on HI write
      bus(1'b1, 3'd1, 4'hF, 32'hFFFF_FFFF, rd, vld);   // -> 41, mtime FFFFFFFF_00000002
      bus(1'b1, 3'd0, 4'hF, 32'hFFFF_FFFF, rd, vld);   // -> 42, mtime all ones
      bus(1'b0, 3'd0, 4'hF, 32'd0, rd, vld);           // -> 43
      check("wrap_pre_lo", {32'd0, rd}, 64'hFFFF_FFFF);
      bus(1'b0, 3'd1, 4'hF, 32'd0, rd, vld);           // -> 44
      check("wrap_hi", {32'd0, rd}, 64'd0);
      bus(1'b0, 3'd0, 4'hF, 32'd0, rd, vld);           // -> 45
      check("wrap_lo", {32'd0, rd}, 64'd1);

      // Byte-enable merge: mtime 2 at cycle 45, only byte 1 replaced
      bus(1'b1, 3'd0, 4'b0010, 32'h0000_AB00, rd, vld);// -> 46
      bus(1'b0, 3'd0, 4'hF, 32'd0, rd, vld);           // -> 47
      check("be_merge", {32'd0, rd}, 64'h0000_AB02);
      bus(1'b0, 3'd6, 4'hF, 32'd0, rd, vld);           // -> 48
      check("unmapped_rd", {32'd0, rd}, 64'd0);
      check("unmapped_rd_vld", {63'd0, vld}, 64'd1);
      bus(1'b1, 3'd6, 4'hF, 32'h1234_5678, rd, vld);   // -> 49
      check("unmapped_wr_vld", {63'd0, vld}, 64'd1);
      bus(1'b0, 3'd0, 4'hF, 32'd0, rd, vld);           // -> 50
      check("mtime_after_unmapped", {32'd0, rd}, 64'h0000_AB05);
      bus(1'b0, 3'd2, 4'hF, 32'd0, rd, vld);           // -> 51
      check("cmp_lo", {32'd0, rd}, 64'hFFFF_FFFF);
      bus(1'b0, 3'd3, 4'hF, 32'd0, rd, vld);           // -> 52
      check("cmp_hi", {32'd0, rd}, 64'd0);
      bus(1'b1, 3'd2, 4'h0, 32'd0, rd, vld);           // -> 53
      check("be0_vld", {63'd0, vld}, 64'd1);
      bus(1'b0, 3'd2, 4'hF, 32'd0, rd, vld);           // -> 54
      check("be0_nochange", {32'd0, rd}, 64'hFFFF_FFFF);
      @(negedge clk);                                  // 55
      check("rvalid_single", {63'd0, rvalid}, 64'd0);

`ifdef IBEX_DEMO_TIMER_PRESCALE_EN
      bus(1'b1, 3'd4, 4'hF, 32'd3, rd, vld);           // -> 56, mtime AB0C
      bus(1'b0, 3'd0, 4'hF, 32'd0, rd, vld);           // -> 57
      check("presc_mtime0", {32'd0, rd}, 64'h0000_AB0C);
      repeat (3) @(negedge clk);                       // 60
      bus(1'b0, 3'd0, 4'hF, 32'd0, rd, vld);           // -> 61
      check("presc_mtime1", {32'd0, rd}, 64'h0000_AB0D);
      repeat (3) @(negedge clk);                       // 64
      bus(1'b0, 3'd0, 4'hF, 32'd0, rd, vld);           // -> 65
      check("presc_mtime2", {32'd0, rd}, 64'h0000_AB0E);
      bus(1'b0, 3'd4, 4'hF, 32'd0, rd, vld);
      check("presc_reg", {32'd0, rd}, 64'd3);
`else
      bus(1'b1, 3'd4, 4'hF, 32'd3, rd, vld);           // -> 56, ignored
      bus(1'b0, 3'd4, 4'hF, 32'd0, rd, vld);           // -> 57
      check("off4_zero", {32'd0, rd}, 64'd0);
      bus(1'b0, 3'd0, 4'hF, 32'd0, rd, vld);           // -> 58
      check("no_presc_mtime", {32'd0, rd}, 64'h0000_AB0D);
`endif

      // Drive interrupt high, then reset in the middle of a read
      bus(1'b1, 3'd2, 4'hF, 32'd0, rd, vld);
      @(negedge clk);
      check("intr_pre_rst", {63'd0, intr}, 64'd1);
      req  = 1'b1;
      we   = 1'b0;
      addr = 32'd0;
      be   = 4'hF;
      #1 rst_ni = 1'b0;
      @(negedge clk);
      req = 1'b0;
      check("midrst_rvalid", {63'd0, rvalid}, 64'd0);
      check("midrst_rdata", {32'd0, rdata}, 64'd0);
      check("midrst_intr", {63'd0, intr}, 64'd0);
      rst_ni = 1'b1;                                   // R
      bus(1'b0, 3'd3, 4'hF, 32'd0, rd, vld);           // -> R+1
      check("rst_cmp_hi", {32'd0, rd}, 64'hFFFF_FFFF);
      bus(1'b0, 3'd0, 4'hF, 32'd0, rd, vld);           // -> R+2
      check("rst_mtime", {32'd0, rd}, 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
